// File: rtl/counter_mode_controller.sv
// Four-mode counter sequencer (mod-LO/mod-HI, up/down) with valid/ready mode-change requests.
// Optional feature macro: AUTO_CYCLE_EN (advance to the next mode at every terminal count in RUN).
module counter_mode_controller #(
  parameter int WIDTH  = 4,
  parameter int MOD_LO = 5,
  parameter int MOD_HI = 10
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic             req_force,
  output logic [WIDTH-1:0] cnt,
  output logic [1:0]       mode,
  output logic             tc,
  output logic             switch_done
);

  typedef enum logic {RUN, PEND} state_t;

  localparam logic [WIDTH-1:0] LO_LAST = WIDTH'(MOD_LO - 1);
  localparam logic [WIDTH-1:0] HI_LAST = WIDTH'(MOD_HI - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt_n, stepped;
  logic [1:0]       mode_n, pend_mode, pend_mode_n;
  logic             pend_force, pend_force_n;
  logic             switch_done_n;
  logic             apply;

  // Mode bit 0 selects down-counting, bit 1 selects the HI modulus
  function automatic logic [WIDTH-1:0] start_of(input logic [1:0] m);
    if (!m[0]) return '0;
    return m[1] ? HI_LAST : LO_LAST;
  endfunction

  function automatic logic [WIDTH-1:0] term_of(input logic [1:0] m);
    if (m[0]) return '0;
    return m[1] ? HI_LAST : LO_LAST;
  endfunction

  assign tc        = (cnt == term_of(mode));
  assign req_ready = (state == RUN);
  assign apply     = (state == PEND) && (pend_force || !en || tc);

  always_comb begin
    stepped = cnt;
    if (en) begin
      if (tc)           stepped = start_of(mode);
      else if (mode[0]) stepped = cnt - ONE;
      else              stepped = cnt + ONE;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = stepped;
    mode_n        = mode;
    pend_mode_n   = pend_mode;
    pend_force_n  = pend_force;
    switch_done_n = 1'b0;
    case (state)
      RUN: begin
        if (req_valid) begin
          pend_mode_n  = req_mode;
          pend_force_n = req_force;
          state_n      = PEND;
        end
`ifdef AUTO_CYCLE_EN
        if (en && tc) begin
          mode_n        = mode + 2'd1;
          cnt_n         = start_of(mode + 2'd1);
          switch_done_n = 1'b1;
        end
`endif
      end
      PEND: begin
        // The apply load replaces any wrap or auto-advance on this edge
        if (apply) begin
          mode_n        = pend_mode;
          cnt_n         = start_of(pend_mode);
          switch_done_n = 1'b1;
          state_n       = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= RUN;
      cnt         <= '0;
      mode        <= 2'd0;
      pend_mode   <= 2'd0;
      pend_force  <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mode        <= mode_n;
      pend_mode   <= pend_mode_n;
      pend_force  <= pend_force_n;
      switch_done <= switch_done_n;
    end
  end

endmodule
